alu_result_stage: RTL

Registered output stage directly downstream of the 32-bit ALU function units (NOT/AND/OR/ADD). It captures one ALU result per valid/ready transfer and derives zero and negative flags. It presents the result, flags and opcode to the consumer through a 2-entry skid buffer. in_ready is fully registered, so there is no combinational path from out_ready back to the ALU.

---
 rtl/alu_result_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// ALU result output stage: captures results with zero/negative flags
// and presents them through a 2-entry skid buffer with registered in_ready.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OP_W-1:0]  out_op,
    output logic             out_zero,
    output logic             out_negative,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [OP_W-1:0]  op;
        logic             zero;
        logic             neg;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic             rdy_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_xfer;
    logic             out_xfer;

    // Flags are fixed at capture time and travel with the data.
    always_comb begin
        in_entry.result = in_result;
        in_entry.op     = in_op;
        in_entry.zero   = (in_result == '0);
        in_entry.neg    = in_result[WIDTH-1];
    end

    assign in_xfer  = in_valid & rdy_q;
    assign out_xfer = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_entry;
                end else if (in_xfer) begin
                    skid_d  = in_entry;
                    state_d = TWO;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (out_xfer && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != TWO);
            count_q <= count_d;
        end
    end

    assign in_ready     = rdy_q;
    assign out_valid    = (state_q != EMPTY);
    assign out_result   = main_q.result;
    assign out_op       = main_q.op;
    assign out_zero     = main_q.zero;
    assign out_negative = main_q.neg;
    assign out_count    = count_q;

endmodule
